edge_event_sequencer: RTL

- Programmable hardware sequencer of edge-controlled waits on a small set of monitored signals.
- Steps through a table of wait conditions: any edge, posedge, negedge, or an OR of two edge events on different signals.
- For each satisfied step it reports the step index, the cycle timestamp and which term fired.
- Used as the synthesizable counterpart of event-control test sequences, and as a sequencing controller for edge-triggered checkers.

---
 rtl/edge_event_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/edge_event_sequencer.sv
// Table-driven sequencer of edge waits on NSIG monitored signals.
// Reports step index, timestamp and firing term for each satisfied step; outputs are registered.
module edge_event_sequencer #(
   parameter int NSIG  = 4,
   parameter int DEPTH = 8,
   parameter int TW    = 16,
   localparam int SW   = (NSIG > 1) ? $clog2(NSIG) : 1,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = 2*SW + 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSIG-1:0] sig_in,
   input  logic            cfg_we,
   input  logic [AW-1:0]   cfg_addr,
   input  logic [CW-1:0]   cfg_data,
   input  logic            start,
   input  logic            abort,
   output logic            busy,
   output logic            done,
   output logic            hit,
   output logic [AW-1:0]   hit_step,
   output logic [TW-1:0]   hit_time,
   output logic [1:0]      hit_src
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   state_t            state_r, next_s;
   logic [CW-1:0]     table_r [DEPTH];
   logic [NSIG-1:0]   prev_r;
   logic              primed_r;
   logic [TW-1:0]     timer_r;
   logic [AW-1:0]     ptr_r;

   logic [NSIG-1:0]   rise_s, fall_s;
   logic [CW-1:0]     word_s;
   logic              a_s, b_s, match_s, last_s, end_s;
   logic              accept_s, adv_s, load_s, cfg_ok_s;

   // Edge event of one term; a select beyond the last signal matches no bit and never fires.
   function automatic logic term_fire(input logic [1:0]      mode,
                                      input logic [SW-1:0]   sel,
                                      input logic [NSIG-1:0] rise,
                                      input logic [NSIG-1:0] fall);
      logic r, f, fire;
      r = 1'b0;
      f = 1'b0;
      for (int i = 0; i < NSIG; i++) begin
         if (int'(sel) == i) begin
            r = rise[i];
            f = fall[i];
         end
      end
      case (mode)
         2'b00:   fire = r | f;
         2'b01:   fire = r;
         2'b10:   fire = f;
         default: fire = 1'b0;
      endcase
      return fire;
   endfunction

   assign rise_s  = primed_r ? (sig_in & ~prev_r) : {NSIG{1'b0}};
   assign fall_s  = primed_r ? (~sig_in & prev_r) : {NSIG{1'b0}};
   assign word_s  = table_r[ptr_r];
   assign a_s     = term_fire(word_s[SW+1:SW], word_s[SW-1:0], rise_s, fall_s);
   assign b_s     = word_s[2*SW+4] &
                    term_fire(word_s[2*SW+3:2*SW+2], word_s[2*SW+1:SW+2], rise_s, fall_s);
   assign match_s = a_s | b_s;
   assign last_s  = word_s[2*SW+5];
   assign end_s   = last_s | (ptr_r == AW'(DEPTH-1));
   assign adv_s   = accept_s & ~end_s;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state decode; abort takes priority over a same-cycle match
   always_comb begin
      next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) next_s = ST_WAIT;
            else       next_s = ST_IDLE;
         end
         ST_WAIT: begin
            if (abort)                 next_s = ST_IDLE;
            else if (match_s && end_s) next_s = ST_FIN;
            else                       next_s = ST_WAIT;
         end
         ST_FIN:  next_s = ST_IDLE;
         default: next_s = ST_IDLE;
      endcase
   end

   // Per-state control strobes
   always_comb begin
      accept_s = 1'b0;
      load_s   = 1'b0;
      cfg_ok_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            load_s   = start;
            cfg_ok_s = cfg_we && (int'(cfg_addr) < DEPTH);
         end
         ST_WAIT: accept_s = match_s & ~abort;
         ST_FIN:  accept_s = 1'b0;
         default: accept_s = 1'b0;
      endcase
   end

   // Free-running timer, edge history and priming flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_r  <= {TW{1'b0}};
         prev_r   <= {NSIG{1'b0}};
         primed_r <= 1'b0;
      end else begin
         timer_r  <= timer_r + TW'(1);
         prev_r   <= sig_in;
         primed_r <= 1'b1;
      end
   end

   // Wait table and step pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) table_r[i] <= {CW{1'b0}};
         ptr_r <= {AW{1'b0}};
      end else begin
         if (cfg_ok_s) table_r[cfg_addr] <= cfg_data;
         if (load_s)     ptr_r <= {AW{1'b0}};
         else if (adv_s) ptr_r <= ptr_r + AW'(1);
      end
   end

   // Registered status and hit report; done follows the cycle spent in FIN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         hit      <= 1'b0;
         hit_step <= {AW{1'b0}};
         hit_time <= {TW{1'b0}};
         hit_src  <= 2'b00;
      end else begin
         busy <= (next_s == ST_WAIT);
         done <= (state_r == ST_FIN);
         hit  <= accept_s;
         if (accept_s) begin
            hit_step <= ptr_r;
            hit_time <= timer_r;
            hit_src  <= {b_s, a_s};
         end
      end
   end

endmodule
